// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle RV32I-subset core
// with a shared instruction/data memory. Decodes the latched IR, steps
// through FETCH..writeback, drives the datapath control inputs and counts
// retired instructions.
// Optional feature macro: CTRL_JALR_EN adds the JALR state (opcode 1100111,
// funct3 000). When undefined, that opcode decodes as illegal and traps.
module multicycle_controller #(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero_flag,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               instruction_or_data,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_control,
  output logic               illegal_instr,
  output logic               retire,
  output logic [CNT_W-1:0]   retire_count,
  output logic [STATE_W-1:0] state_out
);

  // State encoding is fixed so state_out is stable for debug tools.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
`ifdef CTRL_JALR_EN
    , S_JALR   = 4'd13
`endif
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t     state, next_state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic       retire_raw;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  // Register fields and immediates belong to the datapath, not to control.
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // ALU operation for R/I arithmetic; I-type never subtracts.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       b5,
                                            input logic       is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // State register; reset aborts any partial instruction back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Sticky illegal flag, raised on the transition into TRAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    illegal_instr <= 1'b0;
    else if (next_state == S_TRAP) illegal_instr <= 1'b1;
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           retire_count <= '0;
    else if (retire_raw) retire_count <= retire_count + CNT_W'(1);
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    next_state          = state;
    pc_write_raw        = 1'b0;
    ir_write_raw        = 1'b0;
    mem_write_raw       = 1'b0;
    reg_write_raw       = 1'b0;
    retire_raw          = 1'b0;
    instruction_or_data = 1'b0;
    result_src          = 2'b00;
    alu_src_a           = 2'b00;
    alu_src_b           = 2'b00;
    alu_control         = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b01;
        result_src   = 2'b10;
        next_state   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target old_pc+imm is computed speculatively here.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            next_state = S_JAL;
          OP_LUI:            next_state = S_LUI;
`ifdef CTRL_JALR_EN
          OP_JALR:           next_state = (funct3 == 3'b000) ? S_JALR : S_TRAP;
`endif
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        instruction_or_data = 1'b1;
        result_src          = 2'b00;
        next_state          = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWRITE: begin
        instruction_or_data = 1'b1;
        result_src          = 2'b00;
        mem_write_raw       = 1'b1;
        retire_raw          = 1'b1;
        next_state          = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b00;
        alu_control = alu_decode(funct3, f7b5, 1'b1);
        next_state  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = alu_decode(funct3, f7b5, 1'b0);
        next_state  = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = 2'b00;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b00;
        alu_control  = ALU_SUB;
        result_src   = 2'b00;
        // funct3[0]: 0 = BEQ, 1 = BNE
        pc_write_raw = funct3[0] ? ~zero_flag : zero_flag;
        retire_raw   = 1'b1;
        next_state   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in alu_out; link value old_pc+4 is formed now.
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        result_src   = 2'b00;
        pc_write_raw = 1'b1;
        next_state   = S_ALUWB;
      end
`ifdef CTRL_JALR_EN
      S_JALR: begin
        // Overwrite alu_out with rs1+imm so JAL jumps there; LSB left as is.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        next_state = S_JAL;
      end
`endif
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // No writes or retirements may escape while reset is held.
  assign pc_write  = pc_write_raw  & ~reset;
  assign ir_write  = ir_write_raw  & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign retire    = retire_raw    & ~reset;
  assign state_out = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a stimulus process queues the
// expected per-cycle control word for each instruction; a monitor pops and
// compares one entry every cycle while entries are pending.
module tb_multicycle_controller;

  localparam int CW = 4;  // narrow counter so wrap-around is exercised

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, ER = 4'd6, EI = 4'd7, LU = 4'd8, AWB = 4'd9,
                         BR = 4'd10, JL = 4'd11, TR = 4'd12, JR = 4'd13;

  logic          clk = 1'b0, reset = 1'b1, zero_flag = 1'b0;
  logic [31:0]   instr = 32'h0;
  logic          pc_write, ir_write, mem_write, reg_write, iord;
  logic [1:0]    result_src, alu_src_a, alu_src_b;
  logic [3:0]    alu_control, state_out;
  logic          illegal_instr, retire;
  logic [CW-1:0] retire_count;

  multicycle_controller #(.STATE_W(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero_flag(zero_flag),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .instruction_or_data(iord), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .illegal_instr(illegal_instr), .retire(retire), .retire_count(retire_count),
    .state_out(state_out));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, irw, mw, rw, iord;
    logic [1:0]  rs, a, b;
    logic [3:0]  alu;
    logic        ill, ret;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [31:0] m_cnt = 0;

  // ALU code from the instruction's funct fields, straight from the op table.
  function automatic logic [3:0] alu_ref(logic [2:0] f3, logic b5, logic is_r);
    logic [3:0] tbl[8];
    tbl = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_r && b5) return 4'd1;
    if (f3 == 3'd5 && b5)         return 4'd8;
    return tbl[f3];
  endfunction

  // Expected control word for one step of an instruction.
  function automatic exp_t ctl(logic [3:0] s, logic [31:0] ins, logic z);
    exp_t e;
    e = '0;
    e.st = s;
    case (s)
      F:   begin e.irw = 1; e.pcw = 1; e.b = 2'b01; e.rs = 2'b10; end
      D:   begin e.a = 2'b10; e.b = 2'b10; end
      MA:  begin e.a = 2'b01; e.b = 2'b10; end
      MR:  begin e.iord = 1; end
      MWB: begin e.rs = 2'b01; e.rw = 1; e.ret = 1; end
      MW:  begin e.iord = 1; e.mw = 1; e.ret = 1; end
      ER:  begin e.a = 2'b01; e.alu = alu_ref(ins[14:12], ins[30], 1'b1); end
      EI:  begin e.a = 2'b01; e.b = 2'b10; e.alu = alu_ref(ins[14:12], ins[30], 1'b0); end
      LU:  begin e.a = 2'b11; e.b = 2'b10; end
      AWB: begin e.rw = 1; e.ret = 1; end
      BR:  begin e.a = 2'b01; e.alu = 4'd1; e.ret = 1;
                 e.pcw = (ins[14:12] == 3'd0) ? z : ~z; end
      JL:  begin e.a = 2'b10; e.b = 2'b01; e.pcw = 1; end
      JR:  begin e.a = 2'b01; e.b = 2'b10; end
      TR:  begin e.ill = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Queue the expected trace of one instruction (at most maxlen steps).
  task automatic issue(input logic [31:0] ins, input logic z, input int ntrap,
                       input int maxlen, output bit trapped);
    logic [3:0] seq[$];
    logic [2:0] f3;
    exp_t       e;
    f3 = ins[14:12];
    seq = '{F, D};
    trapped = 0;
    case (ins[6:0])
      7'b0000011: seq = '{F, D, MA, MR, MWB};
      7'b0100011: seq = '{F, D, MA, MW};
      7'b0110011: seq = '{F, D, ER, AWB};
      7'b0010011: seq = '{F, D, EI, AWB};
      7'b1100011: if (f3 < 3'd2) seq = '{F, D, BR}; else trapped = 1;
      7'b1101111: seq = '{F, D, JL, AWB};
      7'b0110111: seq = '{F, D, LU, AWB};
`ifdef CTRL_JALR_EN
      7'b1100111: if (f3 == 3'd0) seq = '{F, D, JR, JL, AWB}; else trapped = 1;
`endif
      default: trapped = 1;
    endcase
    if (trapped) for (int i = 0; i < ntrap; i++) seq.push_back(TR);
    instr = ins;
    zero_flag = z;
    for (int i = 0; i < seq.size() && i < maxlen; i++) begin
      e = ctl(seq[i], ins, z);
      e.cnt = m_cnt;
      q.push_back(e);
      if (e.ret) m_cnt = (m_cnt + 1) & ((32'd1 << CW) - 1);
    end
  endtask

  // Wait until the monitor has drained the queue; ends 1ns past a posedge.
  task automatic wait_done();
    int n = 0;
    do begin @(posedge clk); n++; end while (q.size() != 0 && n < 400);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic check_rst(input string name);
    checks++;
    if ({state_out, pc_write, ir_write, mem_write, reg_write, retire,
         illegal_instr, 28'(retire_count)} !== {F, 6'b0, 28'd0}) begin
      errors++;
      $display("FAIL %s state=%0d pcw=%b irw=%b mw=%b rw=%b ret=%b ill=%b cnt=%0d required state=0 all zero",
               name, state_out, pc_write, ir_write, mem_write, reg_write,
               retire, illegal_instr, retire_count);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_cnt = 0;
    #1 check_rst("reset_async");
    @(posedge clk); #1 check_rst("reset_hold");
    reset = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins, input logic z, input int ntrap);
    bit t;
    issue(ins, z, ntrap, 99, t);
    wait_done();
    if (t) do_reset();
  endtask

  exp_t m_e, m_a;
  // Monitor: one expected control word per cycle while work is pending.
  always @(negedge clk) begin
    if (!reset && q.size() > 0) begin
      m_e = q.pop_front();
      m_a = '{state_out, pc_write, ir_write, mem_write, reg_write, iord,
              result_src, alu_src_a, alu_src_b, alu_control, illegal_instr,
              retire, 32'(retire_count)};
      checks++;
      if (m_a !== m_e) begin
        errors++;
        $display("FAIL step_state%0d instr=%h actual=%h required=%h",
                 m_e.st, instr, m_a, m_e);
      end
    end
  end

  logic [6:0] ops[10];
  initial begin
    bit t;
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b1100111, 7'b0000000, 7'b1111111};
    #2 check_rst("reset_initial");
    @(posedge clk); #1 check_rst("reset_initial_hold");
    reset = 1'b0;

    run(32'h00500093, 1'b0, 4);   // addi
    run(32'h40208033, 1'b0, 4);   // sub
    run(32'h4020D013, 1'b0, 4);   // srai
    run(32'h00000463, 1'b1, 4);   // beq taken
    run(32'h00000463, 1'b0, 4);   // beq not taken
    run(32'h0000A083, 1'b0, 4);   // lw
    run(32'h0010A023, 1'b0, 4);   // sw
    run(32'h000080E7, 1'b0, 4);   // jalr (traps when feature absent)
    run(32'h00000463, 1'b1, 4);

    // Reset asserted while in MEMREAD of a load.
    issue(32'h0000A083, 1'b0, 0, 3, t);
    wait_done();
    checks++;
    if (state_out !== MR) begin
      errors++;
      $display("FAIL pre_reset_state actual=%0d required=%0d", state_out, MR);
    end
    do_reset();

    run(32'hFFFFFFFF, 1'b0, 100); // illegal, held for 100 cycles

    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      run(ins, 1'($urandom_range(0, 1)), 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
